// File: rtl/exu_seq.sv
// exu_seq: multi-cycle FETCH -> WAIT_IF -> DECODE -> EXEC -> WB sequencer for the NPC core.
// Owns the PC, handshakes with the instruction port and exu, and drives the regfile write port.
// Optional feature: define EXU_SEQ_PERF_EN to add perf_cycle / perf_instret counters.
module exu_seq #(
  parameter logic [63:0] RESET_PC   = 64'h8000_0000,
  parameter int unsigned IF_TIMEOUT = 16,
  parameter int unsigned EX_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req,
  output logic [63:0] if_addr,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  output logic [31:0] id_inst,
  input  logic [4:0]  id_rd,
  input  logic        id_wen,
  input  logic        id_halt,
  output logic        ex_start,
  input  logic        ex_done,
  input  logic [63:0] ex_data,
  input  logic        ex_taken,
  input  logic [63:0] ex_target,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic [63:0] pc,
  output logic        halted,
  output logic [1:0]  err
`ifdef EXU_SEQ_PERF_EN
  ,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret
`endif
);

  typedef enum logic [2:0] {
    StFetch,
    StWaitIf,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrFetch = 2'd1;
  localparam logic [1:0] ErrExec  = 2'd2;

  state_e      state_q;
  logic [15:0] timer_q;   // cycles already spent in the current wait state
  logic        wen_q;     // decoder's write-enable for the instruction in flight
  logic [63:0] npc_q;     // next PC, resolved when exu completes

  logic [15:0] timer_inc;
  logic        if_expired;
  logic        ex_expired;
  logic [63:0] redirect_pc;

  // Timer helpers: saturating increment and expiry on the last allowed wait cycle
  always_comb begin
    timer_inc   = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
    if_expired  = {16'd0, timer_q} >= (IF_TIMEOUT - 32'd1);
    ex_expired  = {16'd0, timer_q} >= (EX_TIMEOUT - 32'd1);
    redirect_pc = ex_target & ~64'd1;
  end

  // The fetch address is the architectural PC, which is stable for the whole fetch.
  // ex_start is decoded from DECODE because it depends on the decoder's same-cycle id_halt.
  always_comb begin
    if_addr  = pc;
    ex_start = (state_q == StDecode) && !id_halt;
  end

  // Main sequencer: state, PC, latched instruction/result and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      timer_q <= '0;
      wen_q   <= 1'b0;
      npc_q   <= '0;
      if_req  <= 1'b0;
      id_inst <= '0;
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      pc      <= RESET_PC;
      halted  <= 1'b0;
      err     <= ErrNone;
    end else begin
      if_req <= 1'b0;
      wb_en  <= 1'b0;
      unique case (state_q)
        StFetch: begin
          if_req  <= 1'b1;
          timer_q <= '0;
          state_q <= StWaitIf;
        end
        StWaitIf: begin
          // A response in the expiry cycle still counts as a fetch.
          if (if_valid) begin
            id_inst <= if_inst;
            state_q <= StDecode;
          end else if (if_expired) begin
            err     <= ErrFetch;
            halted  <= 1'b1;
            state_q <= StHalt;
          end else begin
            timer_q <= timer_inc;
          end
        end
        StDecode: begin
          timer_q <= '0;
          if (id_halt) begin
            halted  <= 1'b1;
            state_q <= StHalt;
          end else begin
            wb_rd   <= id_rd;
            wen_q   <= id_wen;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (ex_done) begin
            wb_data <= ex_data;
            wb_en   <= wen_q && (wb_rd != 5'd0);
            npc_q   <= ex_taken ? redirect_pc : pc + 64'd4;
            state_q <= StWb;
          end else if (ex_expired) begin
            err     <= ErrExec;
            halted  <= 1'b1;
            state_q <= StHalt;
          end else begin
            timer_q <= timer_inc;
          end
        end
        StWb: begin
          pc      <= npc_q;
          state_q <= StFetch;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          halted  <= 1'b1;
          state_q <= StHalt;
        end
      endcase
    end
  end

`ifdef EXU_SEQ_PERF_EN
  // Performance counters: live cycles and retired instructions (every WB, written or not)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycle   <= '0;
      perf_instret <= '0;
    end else begin
      if (state_q != StHalt) begin
        perf_cycle <= perf_cycle + 64'd1;
      end
      if (state_q == StWb) begin
        perf_instret <= perf_instret + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exu_seq.sv
// tb_exu_seq: self-checking bench for exu_seq. The bench plays instruction memory, decoder and
// exu; a transaction-level model predicts PC flow, writebacks and per-instruction latency.
module tb_exu_seq;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int IF_TO = 16;
  localparam int EX_TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] id_inst;
  logic [4:0]  id_rd;
  logic        id_wen;
  logic        id_halt;
  logic        ex_start;
  logic        ex_done;
  logic [63:0] ex_data;
  logic        ex_taken;
  logic [63:0] ex_target;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [63:0] pc;
  logic        halted;
  logic [1:0]  err;
`ifdef EXU_SEQ_PERF_EN
  logic [63:0] perf_cycle;
  logic [63:0] perf_instret;
`endif

  always #5 clk = ~clk;

  exu_seq #(
    .RESET_PC  (RESET_PC),
    .IF_TIMEOUT(IF_TO),
    .EX_TIMEOUT(EX_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_valid (if_valid),
    .if_inst  (if_inst),
    .id_inst  (id_inst),
    .id_rd    (id_rd),
    .id_wen   (id_wen),
    .id_halt  (id_halt),
    .ex_start (ex_start),
    .ex_done  (ex_done),
    .ex_data  (ex_data),
    .ex_taken (ex_taken),
    .ex_target(ex_target),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .pc       (pc),
    .halted   (halted),
`ifdef EXU_SEQ_PERF_EN
    .perf_cycle  (perf_cycle),
    .perf_instret(perf_instret),
`endif
    .err      (err)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int wb_pulses = 0;

  // Reference model state
  logic [63:0] model_pc;
  int          prev_req_cyc;
  int          exp_period;
  int          instret;
  int          exp_wb_pulses;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (wb_en === 1'b1) wb_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    if_valid  = 1'b0;
    if_inst   = '0;
    id_rd     = '0;
    id_wen    = 1'b0;
    id_halt   = 1'b0;
    ex_done   = 1'b0;
    ex_data   = '0;
    ex_taken  = 1'b0;
    ex_target = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_pc     = RESET_PC;
    prev_req_cyc = -1;
    exp_period   = 0;
    instret      = 0;
  endtask

  task automatic wait_if_req();
    int n;
    n = 0;
    while (if_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (if_req !== 1'b1) begin
      n_fails++;
      $display("FAIL if_req_wait: if_req=%b, required 1 within 40 cycles", if_req);
    end
  endtask

  // One full instruction: fl = cycles from if_req to if_valid, el = ex_start to ex_done (>=1)
  task automatic run_instr(input int fl, input int el, input logic [4:0] rd, input logic wen,
                           input logic [63:0] data, input logic taken, input logic [63:0] tgt);
    logic [31:0] inst;
    logic        exp_wb;
    inst = $urandom;
    wait_if_req();
    n_checks++;
    if (if_addr !== model_pc) begin
      n_fails++;
      $display("FAIL if_addr: got %h, required %h", if_addr, model_pc);
    end
    if (prev_req_cyc >= 0) begin
      n_checks++;
      if (cyc - prev_req_cyc != exp_period) begin
        n_fails++;
        $display("FAIL period: got %0d cycles, required %0d", cyc - prev_req_cyc, exp_period);
      end
    end
    prev_req_cyc = cyc;
    exp_period   = 4 + fl + el;
    // exu completions before ex_start are junk and must be ignored
    for (int i = 0; i < fl; i++) begin
      ex_done = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ex_done  = 1'b0;
    if_valid = 1'b1;
    if_inst  = inst;
    id_rd    = rd;
    id_wen   = wen;
    id_halt  = 1'b0;
    @(negedge clk);
    if_valid = 1'b0;
    n_checks++;
    if (ex_start !== 1'b1 || id_inst !== inst) begin
      n_fails++;
      $display("FAIL decode: ex_start=%b id_inst=%h, required 1 and %h", ex_start, id_inst, inst);
    end
    @(negedge clk);
    n_checks++;
    if (ex_start !== 1'b0) begin
      n_fails++;
      $display("FAIL ex_start_pulse: got %b in EXEC, required 0", ex_start);
    end
    for (int i = 1; i < el; i++) @(negedge clk);
    ex_done   = 1'b1;
    ex_data   = data;
    ex_taken  = taken;
    ex_target = tgt;
    @(negedge clk);
    ex_done   = 1'b0;
    ex_data   = {$urandom, $urandom};
    ex_taken  = 1'($urandom_range(0, 1));
    ex_target = {$urandom, $urandom};
    exp_wb = wen && (rd != 5'd0);
    n_checks++;
    if (wb_en !== exp_wb || pc !== model_pc) begin
      n_fails++;
      $display("FAIL wb_en: wb_en=%b pc=%h, required %b and %h", wb_en, pc, exp_wb, model_pc);
    end
    if (exp_wb) begin
      n_checks++;
      if (wb_rd !== rd || wb_data !== data) begin
        n_fails++;
        $display("FAIL wb_port: rd=%0d data=%h, required %0d and %h", wb_rd, wb_data, rd, data);
      end
      exp_wb_pulses++;
    end
    model_pc = taken ? (tgt & ~64'd1) : model_pc + 64'd4;
    instret++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_checks++;
    if (pc !== RESET_PC || id_inst !== 32'd0 || wb_rd !== 5'd0 || wb_data !== 64'd0) begin
      n_fails++;
      $display("FAIL reset_regs: pc=%h id_inst=%h wb_rd=%0d wb_data=%h, required %h/0/0/0",
               pc, id_inst, wb_rd, wb_data, RESET_PC);
    end
    n_checks++;
    if ({if_req, ex_start, wb_en, halted, err} !== 6'd0) begin
      n_fails++;
      $display("FAIL reset_strobes: if_req=%b ex_start=%b wb_en=%b halted=%b err=%0d, required 0",
               if_req, ex_start, wb_en, halted, err);
    end
`ifdef EXU_SEQ_PERF_EN
    n_checks++;
    if (perf_cycle !== 64'd0 || perf_instret !== 64'd0) begin
      n_fails++;
      $display("FAIL reset_perf: cycle=%0d instret=%0d, required 0", perf_cycle, perf_instret);
    end
`endif
    rst = 1'b0;
    model_pc     = RESET_PC;
    prev_req_cyc = -1;
    instret      = 0;
  endtask

  task automatic test_directed();
    int base;
    base = wb_pulses;
    exp_wb_pulses = 0;
    run_instr(2, 1, 5'd1, 1'b1, 64'd5, 1'b0, 64'd0);                      // addi x1,x0,5
    run_instr(1, 2, 5'd0, 1'b1, 64'd7, 1'b0, 64'd0);                      // write to x0
    run_instr(0, 1, 5'd2, 1'b1, 64'h1234, 1'b1, 64'h0000_0000_8000_0101); // taken branch
    run_instr(3, 3, 5'd4, 1'b0, 64'h55, 1'b0, 64'd0);                     // next at 0x80000100
    wait_if_req();
    n_checks++;
    if (if_addr !== 64'h8000_0104 || if_addr !== model_pc) begin
      n_fails++;
      $display("FAIL directed_pc: got %h, required %h", if_addr, 64'h8000_0104);
    end
    n_checks++;
    if (wb_pulses - base != exp_wb_pulses) begin
      n_fails++;
      $display("FAIL directed_wb_count: got %0d, required %0d", wb_pulses - base, exp_wb_pulses);
    end
  endtask

  task automatic test_random();
    int base;
    do_reset();
    base = wb_pulses;
    exp_wb_pulses = 0;
    for (int k = 0; k < 25; k++) begin
      run_instr($urandom_range(0, 5), $urandom_range(1, 6), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
                {$urandom, $urandom});
    end
    wait_if_req();
    n_checks++;
    if (if_addr !== model_pc || wb_pulses - base != exp_wb_pulses) begin
      n_fails++;
      $display("FAIL random_end: addr=%h wb=%0d, required %h and %0d", if_addr,
               wb_pulses - base, model_pc, exp_wb_pulses);
    end
`ifdef EXU_SEQ_PERF_EN
    n_checks++;
    if (perf_instret !== 64'(instret)) begin
      n_fails++;
      $display("FAIL perf_instret: got %0d, required %0d", perf_instret, instret);
    end
`endif
  endtask

  task automatic test_fetch_timeout();
    int pulses;
    do_reset();
    wait_if_req();
    repeat (IF_TO - 1) @(negedge clk);
    n_checks++;
    if (halted !== 1'b0) begin
      n_fails++;
      $display("FAIL if_timeout_early: halted=%b in wait cycle %0d, required 0", halted, IF_TO);
    end
    @(negedge clk);
    n_checks++;
    if (halted !== 1'b1 || err !== 2'd1) begin
      n_fails++;
      $display("FAIL if_timeout: halted=%b err=%0d, required 1 and 1", halted, err);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if_valid = 1'($urandom_range(0, 1));
      if_inst  = $urandom;
      ex_done  = 1'($urandom_range(0, 1));
      @(negedge clk);
      pulses += int'(if_req) + int'(ex_start) + int'(wb_en);
    end
    clear_inputs();
    n_checks++;
    if (pulses != 0 || pc !== RESET_PC || id_inst !== 32'd0 || halted !== 1'b1) begin
      n_fails++;
      $display("FAIL halt_frozen: pulses=%0d pc=%h id_inst=%h halted=%b, required 0/%h/0/1",
               pulses, pc, id_inst, halted, RESET_PC);
    end
    // Response on the very last allowed wait cycle wins over expiry
    do_reset();
    run_instr(IF_TO - 1, 1, 5'd3, 1'b1, 64'hAB, 1'b0, 64'd0);
    n_checks++;
    if (halted !== 1'b0 || err !== 2'd0) begin
      n_fails++;
      $display("FAIL if_late_valid: halted=%b err=%0d, required 0 and 0", halted, err);
    end
  endtask

  task automatic test_exec_timeout();
    do_reset();
    wait_if_req();
    if_valid = 1'b1;
    if_inst  = 32'h0000_0013;
    id_rd    = 5'd5;
    id_wen   = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    @(negedge clk);
    repeat (EX_TO - 1) @(negedge clk);
    n_checks++;
    if (halted !== 1'b0) begin
      n_fails++;
      $display("FAIL ex_timeout_early: halted=%b in exec cycle %0d, required 0", halted, EX_TO);
    end
    @(negedge clk);
    n_checks++;
    if (halted !== 1'b1 || err !== 2'd2 || wb_en !== 1'b0) begin
      n_fails++;
      $display("FAIL ex_timeout: halted=%b err=%0d wb_en=%b, required 1/2/0", halted, err, wb_en);
    end
  endtask

  task automatic test_ebreak();
    int pulses;
    do_reset();
    wait_if_req();
    @(negedge clk);
    if_valid = 1'b1;
    if_inst  = 32'h0010_0073;
    id_halt  = 1'b1;
    id_wen   = 1'b1;
    id_rd    = 5'd7;
    @(negedge clk);
    if_valid = 1'b0;
    n_checks++;
    if (ex_start !== 1'b0) begin
      n_fails++;
      $display("FAIL ebreak_start: ex_start=%b, required 0", ex_start);
    end
    @(negedge clk);
    n_checks++;
    if (halted !== 1'b1 || err !== 2'd0) begin
      n_fails++;
      $display("FAIL ebreak_halt: halted=%b err=%0d, required 1 and 0", halted, err);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if_valid = 1'b1;
      if_inst  = $urandom;
      ex_done  = 1'b1;
      @(negedge clk);
      pulses += int'(if_req) + int'(ex_start) + int'(wb_en);
    end
    clear_inputs();
    n_checks++;
    if (pulses != 0 || id_inst !== 32'h0010_0073 || pc !== RESET_PC) begin
      n_fails++;
      $display("FAIL ebreak_frozen: pulses=%0d id_inst=%h pc=%h, required 0/00100073/%h",
               pulses, id_inst, pc, RESET_PC);
    end
  endtask

  task automatic test_reset_mid_exec();
    int base;
    do_reset();
    run_instr(1, 1, 5'd6, 1'b1, 64'h66, 1'b0, 64'd0);
    wait_if_req();
    if_valid = 1'b1;
    if_inst  = 32'h0030_0113;
    id_rd    = 5'd2;
    id_wen   = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({if_req, ex_start, wb_en, halted, err} !== 6'd0 || pc !== RESET_PC
        || id_inst !== 32'd0 || wb_data !== 64'd0) begin
      n_fails++;
      $display("FAIL rst_abort: req=%b start=%b wb=%b pc=%h id_inst=%h wb_data=%h, required 0/RESET_PC",
               if_req, ex_start, wb_en, pc, id_inst, wb_data);
    end
    base = wb_pulses;
    ex_done = 1'b1;
    ex_data = 64'hDEAD;
    @(negedge clk);
    rst = 1'b0;
    model_pc     = RESET_PC;
    prev_req_cyc = -1;
    instret      = 0;
    @(negedge clk);
    n_checks++;
    if (if_req !== 1'b1 || if_addr !== RESET_PC) begin
      n_fails++;
      $display("FAIL rst_restart: if_req=%b if_addr=%h, required 1 and %h", if_req, if_addr, RESET_PC);
    end
`ifdef EXU_SEQ_PERF_EN
    n_checks++;
    if (perf_instret !== 64'd0 || perf_cycle !== 64'd1) begin
      n_fails++;
      $display("FAIL rst_perf: instret=%0d cycle=%0d, required 0 and 1", perf_instret, perf_cycle);
    end
`endif
    ex_done = 1'b0;
    exp_wb_pulses = 0;
    run_instr(2, 2, 5'd9, 1'b1, 64'h99, 1'b0, 64'd0);
    @(negedge clk);
    n_checks++;
    if (wb_pulses - base != exp_wb_pulses) begin
      n_fails++;
      $display("FAIL rst_stale_done: wb pulses=%0d, required %0d", wb_pulses - base, exp_wb_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_fetch_timeout();
    test_exec_timeout();
    test_ebreak();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
